add_mop_collect: RTL and testbench
==================================

ADD_MOP_COLLECT -- requirements
Module: add_mop_collect

Interface
REQ-001 Parameter BW, default 8, SHALL be the operand word width in bits (BW >= 1).
REQ-002 Parameter depth, default 4, SHALL be the number of operand slots per group (depth >= 1).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 in_valid_i  input  1  SHALL indicate in_data_i/in_last_i carry an operand.
REQ-006 in_ready_o  output  1  SHALL indicate the block accepts an operand this cycle.
REQ-007 in_data_i  input  BW  SHALL carry the operand word.
REQ-008 in_last_i  input  1  SHALL mark the final operand of a group shorter than depth.
REQ-009 out_valid_o  output  1  SHALL indicate a complete packed group is presented.
REQ-010 out_ready_i  input  1  SHALL indicate the downstream adder stage consumes the group.
REQ-011 out_ops_o  output  depth*BW  SHALL carry the packed operands, slot i at bits [BW*i +: BW].
REQ-012 out_count_o  output  $clog2(depth+1)  SHALL carry the number of real operands in the group (1..depth).

Function
REQ-013 Block SHALL have two states: FILL and HOLD.
REQ-014 In FILL, in_ready_o SHALL be 1 and out_valid_o SHALL be 0; in HOLD, in_ready_o SHALL be 0 and out_valid_o SHALL be 1.
REQ-015 in_ready_o SHALL NOT depend combinationally on in_valid_i; out_valid_o SHALL NOT depend combinationally on out_ready_i.
REQ-016 Input handshake (in_valid_i & in_ready_o) SHALL write in_data_i into slot cnt and increment cnt, where cnt is the internal slot counter (0..depth-1).
REQ-017 Input handshake with cnt == depth-1 or in_last_i == 1 SHALL move FILL -> HOLD on the same edge; out_count_o SHALL then equal cnt+1 of that handshake.
REQ-018 All slots not written in the current group SHALL read as zero in out_ops_o, so a partial group sums correctly downstream.
REQ-019 in_last_i SHALL be ignored when in_valid_i is 0; with depth == 1 every handshake SHALL complete a group.
REQ-020 In HOLD, out_ops_o and out_count_o SHALL remain stable until out_ready_i is 1.
REQ-021 Output handshake (out_valid_o & out_ready_i) SHALL clear all slots to zero, set cnt to 0, and move HOLD -> FILL on the same edge.
REQ-022 In FILL, out_ready_i SHALL be ignored; in HOLD, in_valid_i/in_data_i/in_last_i SHALL be ignored.
REQ-023 Latency: out_valid_o SHALL assert in the cycle after the completing input handshake; peak throughput SHALL be one group per (operands + 1) cycles.
REQ-024 The block SHALL perform no arithmetic; operand bits SHALL be transferred unmodified.
REQ-025 out_count_o SHALL be 0 whenever out_valid_o is 0.

Reset
REQ-026 With rst_i high at a clock edge, the block SHALL enter FILL with cnt = 0, all slots zero.
REQ-027 After reset: in_ready_o = 1, out_valid_o = 0, out_ops_o = 0, out_count_o = 0.
REQ-028 Reset SHALL take priority over any simultaneous handshake; a partial or held group SHALL be discarded.

Verification (BW=8, depth=4)
REQ-029 Full group: send 0x01,0x02,0x03,0x04 on consecutive cycles, out_ready_i=1 -> out_ops_o = 0x04030201, out_count_o = 4, out_valid_o high one cycle, in_ready_o low that cycle.
REQ-030 Short group: send 0xAA, 0xBB with in_last_i on 0xBB -> out_ops_o = 0x0000BBAA, out_count_o = 2; next group 0x11 (last) -> out_ops_o = 0x00000011 (no stale data).
REQ-031 Backpressure: complete group 0xFF x4, hold out_ready_i=0 for 5 cycles while driving in_valid_i=1 -> out_ops_o = 0xFFFFFFFF stable, in_ready_o = 0, no input consumed; release -> return to FILL next cycle.
REQ-032 Gaps: operands 0x10,0x20,0x30,0x40 with in_valid_i low between each -> out_ops_o = 0x40302010 regardless of gaps.
REQ-033 Reset mid-group: accept 0x05,0x06, assert rst_i one cycle -> out_valid_o = 0, then 0x07 (last) yields out_ops_o = 0x00000007, out_count_o = 1.
REQ-034 Random streams with random valid/ready: per group, sum of out_ops_o slots mod 2^8 SHALL equal sum of the accepted operands of that group mod 2^8.

Source files
------------

// File: rtl/add_mop_collect.sv
// Operand collector for a multi-operand adder: packs up to depth words into
// one zero-padded group and holds it until the adder stage takes it.
module add_mop_collect #(
   parameter int BW    = 8,
   parameter int depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [BW-1:0]              in_data_i,
   input  logic                       in_last_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [depth*BW-1:0]        out_ops_o,
   output logic [$clog2(depth+1)-1:0] out_count_o
);

   localparam int CW   = $clog2(depth + 1);
   localparam int CNTW = (depth > 1) ? $clog2(depth) : 1;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [BW-1:0]   slot_q [depth];
   logic [BW-1:0]   slot_d [depth];

   logic in_fire;
   logic out_fire;
   logic group_done;

   assign in_fire    = in_valid_i && (state_q == FILL);
   assign out_fire   = out_ready_i && (state_q == HOLD);
   assign group_done = in_fire && (in_last_i || (cnt_q == CNTW'(depth - 1)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      if (group_done) begin
         state_d = HOLD;
         cnt_d   = '0;
         count_d = CW'(cnt_q) + CW'(1);
      end else if (in_fire) begin
         cnt_d = cnt_q + CNTW'(1);
      end
      // count_q doubles as the out_count_o value, so it must return to zero in FILL.
      if (out_fire) begin
         state_d = FILL;
         cnt_d   = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FILL;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   // Slots are cleared when a group leaves, so unwritten slots of a short group read as zero.
   for (genvar gi = 0; gi < depth; gi++) begin : g_slot
      always_comb begin
         slot_d[gi] = slot_q[gi];
         if (out_fire) begin
            slot_d[gi] = '0;
         end else if (in_fire && (cnt_q == CNTW'(gi))) begin
            slot_d[gi] = in_data_i;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            slot_q[gi] <= '0;
         end else begin
            slot_q[gi] <= slot_d[gi];
         end
      end

      assign out_ops_o[BW*gi +: BW] = slot_q[gi];
   end

   assign in_ready_o  = (state_q == FILL);
   assign out_valid_o = (state_q == HOLD);
   assign out_count_o = count_q;

endmodule

// File: tb/tb_add_mop_collect.sv
// Scoreboard bench for add_mop_collect (BW=8, depth=4): directed group
// scenarios followed by random valid/ready streams.
module tb_add_mop_collect;

   localparam int BW    = 8;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [7:0]    in_data_i = 8'h00;
   logic          in_last_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [31:0]   out_ops_o;
   logic [2:0]    out_count_o;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_ops_q [$];
   logic [2:0]  exp_cnt_q [$];
   logic [7:0]  exp_sum_q [$];

   logic [31:0] acc_ops;
   int          acc_cnt;
   logic [7:0]  acc_sum;

   add_mop_collect #(.BW(BW), .depth(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_ops_o   (out_ops_o),
      .out_count_o (out_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_reset();
      acc_ops = '0;
      acc_cnt = 0;
      acc_sum = '0;
   endtask

   // Drives one cycle of inputs (called at a falling edge), records the
   // handshakes that the next rising edge will perform, updates the model.
   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r,
                       output logic took_in, output logic took_out,
                       output logic [31:0] ops, output logic [2:0] cnt);
      in_valid_i  = v;
      in_data_i   = d;
      in_last_i   = l;
      out_ready_i = r;
      took_in  = in_ready_o && v && !rst_i;
      took_out = out_valid_o && r && !rst_i;
      ops = out_ops_o;
      cnt = out_count_o;
      if (took_in) begin
         acc_ops[8*acc_cnt +: 8] = d;
         acc_cnt++;
         acc_sum += d;
         if (acc_cnt == DEPTH || l) begin
            exp_ops_q.push_back(acc_ops);
            exp_cnt_q.push_back(3'(acc_cnt));
            exp_sum_q.push_back(acc_sum);
            model_reset();
         end
      end
      @(negedge clk_i);
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      logic ti, to;
      logic [31:0] o;
      logic [2:0] c;
      step(1'b1, d, l, 1'b0, ti, to, o, c);
   endtask

   task automatic collect(output logic got, output logic [31:0] ops, output logic [2:0] cnt);
      logic ti;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) step(1'b0, 8'h00, 1'b0, 1'b1, ti, got, ops, cnt);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      in_valid_i = 1'b1;
      in_data_i = 8'h99;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      in_valid_i = 1'b0;
      vectors += 4;
      if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
      if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
      if (out_ops_o !== 32'h0) begin miscompares++; $display("FAIL reset_ops got %h want 0", out_ops_o); end
      if (out_count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", out_count_o); end
      model_reset();
   endtask

   task automatic test_full_group();
      logic got;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      vectors += 2;
      if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL full_valid got %b want 1", out_valid_o); end
      if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b want 0", in_ready_o); end
      collect(got, ops, cnt);
      vectors++;
      if (!got || exp_ops_q.size() == 0) begin
         miscompares++; $display("FAIL full_timeout got_out %b queued %0d want 1 and >0", got, exp_ops_q.size());
      end else begin
         e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
         vectors += 2;
         if (ops !== e) begin miscompares++; $display("FAIL full_ops got %h want %h", ops, e); end
         if (cnt !== ec) begin miscompares++; $display("FAIL full_count got %0d want %0d", cnt, ec); end
      end
      vectors += 3;
      if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL full_one_cycle got %b want 0", out_valid_o); end
      if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_refill got %b want 1", in_ready_o); end
      if (out_count_o !== 3'd0) begin miscompares++; $display("FAIL full_count_idle got %0d want 0", out_count_o); end
      $display("full_group ops %h count %0d", ops, cnt);
   endtask

   task automatic test_short_group();
      logic got;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      for (int g = 0; g < 2; g++) begin
         if (g == 0) begin send(8'hAA, 1'b0); send(8'hBB, 1'b1); end
         else send(8'h11, 1'b1);
         collect(got, ops, cnt);
         vectors++;
         if (!got || exp_ops_q.size() == 0) begin
            miscompares++; $display("FAIL short_timeout group %0d got_out %b queued %0d", g, got, exp_ops_q.size());
         end else begin
            e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
            vectors += 2;
            if (ops !== e) begin miscompares++; $display("FAIL short_ops group %0d got %h want %h", g, ops, e); end
            if (cnt !== ec) begin miscompares++; $display("FAIL short_count group %0d got %0d want %0d", g, cnt, ec); end
         end
         $display("short_group %0d ops %h count %0d", g, ops, cnt);
      end
   endtask

   task automatic test_backpressure();
      logic got, ti, to;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h5A, 1'b1, 1'b0, ti, to, ops, cnt);
         vectors += 4;
         if (ti !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, ti); end
         if (ops !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL bp_ops cyc %0d got %h want ffffffff", i, ops); end
         if (cnt !== 3'd4) begin miscompares++; $display("FAIL bp_count cyc %0d got %0d want 4", i, cnt); end
         if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid_o); end
      end
      collect(got, ops, cnt);
      vectors++;
      if (!got || exp_ops_q.size() == 0) begin
         miscompares++; $display("FAIL bp_timeout got_out %b queued %0d", got, exp_ops_q.size());
      end else begin
         e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
         vectors += 2;
         if (ops !== e) begin miscompares++; $display("FAIL bp_release_ops got %h want %h", ops, e); end
         if (cnt !== ec) begin miscompares++; $display("FAIL bp_release_count got %0d want %0d", cnt, ec); end
      end
      vectors++;
      if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_refill got %b want 1", in_ready_o); end
      $display("backpressure ops %h count %0d", ops, cnt);
   endtask

   task automatic test_gaps();
      logic got, ti, to;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      for (int i = 1; i <= 4; i++) begin
         send(8'(i * 16), 1'b0);
         if (i < 4) repeat (i) step(1'b0, 8'hEE, 1'b1, 1'b0, ti, to, ops, cnt);
      end
      collect(got, ops, cnt);
      vectors++;
      if (!got || exp_ops_q.size() == 0) begin
         miscompares++; $display("FAIL gaps_timeout got_out %b queued %0d", got, exp_ops_q.size());
      end else begin
         e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
         vectors += 2;
         if (ops !== e) begin miscompares++; $display("FAIL gaps_ops got %h want %h", ops, e); end
         if (cnt !== ec) begin miscompares++; $display("FAIL gaps_count got %0d want %0d", cnt, ec); end
      end
      $display("gaps ops %h count %0d", ops, cnt);
   endtask

   task automatic test_reset_mid_group();
      logic got, ti, to;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      send(8'h05, 1'b0);
      send(8'h06, 1'b0);
      rst_i = 1'b1;
      step(1'b1, 8'h08, 1'b1, 1'b1, ti, to, ops, cnt);
      rst_i = 1'b0;
      model_reset();
      vectors += 3;
      if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", out_valid_o); end
      if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", in_ready_o); end
      if (out_ops_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_ops got %h want 0", out_ops_o); end
      send(8'h07, 1'b1);
      collect(got, ops, cnt);
      vectors++;
      if (!got || exp_ops_q.size() == 0) begin
         miscompares++; $display("FAIL rstmid_timeout got_out %b queued %0d", got, exp_ops_q.size());
      end else begin
         e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
         vectors += 2;
         if (ops !== e) begin miscompares++; $display("FAIL rstmid_ops_after got %h want %h", ops, e); end
         if (cnt !== ec) begin miscompares++; $display("FAIL rstmid_count got %0d want %0d", cnt, ec); end
      end
      $display("reset_mid_group ops %h count %0d", ops, cnt);
   endtask

   task automatic test_random();
      logic got, ti, to, v, l, r;
      logic [7:0] d, s, es;
      logic [31:0] ops, e;
      logic [2:0] cnt, ec;
      int groups = 0;
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 9) < 7);
         l = ($urandom_range(0, 9) < 2);
         r = ($urandom_range(0, 9) < 6);
         d = 8'($urandom_range(0, 255));
         step(v, d, l, r, ti, to, ops, cnt);
         if (to) begin
            vectors++;
            if (exp_ops_q.size() == 0) begin
               miscompares++; $display("FAIL rand_unexpected_group got %h want none", ops);
            end else begin
               e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); es = exp_sum_q.pop_front();
               s = '0;
               for (int i = 0; i < DEPTH; i++) s += ops[8*i +: 8];
               vectors += 2;
               if (ops !== e || cnt !== ec) begin
                  miscompares++; $display("FAIL rand_group %0d got %h/%0d want %h/%0d", groups, ops, cnt, e, ec);
               end
               if (s !== es) begin miscompares++; $display("FAIL rand_sum %0d got %h want %h", groups, s, es); end
               $display("random group %0d ops %h count %0d sum %h", groups, ops, cnt, s);
               groups++;
            end
         end
      end
      if (exp_ops_q.size() != 0) begin
         collect(got, ops, cnt);
         e = exp_ops_q.pop_front(); ec = exp_cnt_q.pop_front(); void'(exp_sum_q.pop_front());
         vectors++;
         if (!got || ops !== e || cnt !== ec) begin
            miscompares++; $display("FAIL rand_drain got %b %h/%0d want 1 %h/%0d", got, ops, cnt, e, ec);
         end
      end
      vectors++;
      if (exp_ops_q.size() != 0) begin
         miscompares++; $display("FAIL rand_leftover got %0d want 0", exp_ops_q.size());
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk_i);
      test_reset();
      test_full_group();
      test_short_group();
      test_backpressure();
      test_gaps();
      test_reset_mid_group();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
